// File: rtl/input_conditioner.sv
// Board-input front end: synchronises and debounces a data switch and a
// push-button for the downstream run-detector FSM.
//   clk        - system clock, rising edge
//   reset      - synchronous, active-low reset
//   sw_in      - raw asynchronous data switch
//   key_in     - raw asynchronous push-button
//   w          - debounced switch level
//   w_rise     - one-cycle pulse when w goes 0->1
//   w_fall     - one-cycle pulse when w goes 1->0
//   step       - one-cycle pulse per debounced key press
//   step_count - step pulses seen, modulo 256

// Single channel: 2-flop synchroniser followed by a STABLE/WAIT debounce FSM.
//   level  - accepted (debounced) level, raw pin polarity
//   flip_c - high in the cycle whose edge flips level
module input_conditioner_db #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic flip_c
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_WAIT   = 1'b1;

  logic          sync1;
  logic          sync2;
  logic [0:0]    state;
  logic [0:0]    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  // State and synchroniser registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
      state <= ST_STABLE;
      cnt   <= '0;
      level <= RESET_LEVEL;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      state <= state_nx;
      cnt   <= cnt_nx;
      level <= level ^ flip_c;
    end
  end

  // Next-state: a new level must persist DEBOUNCE_CYCLES edges to be accepted
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    flip_c   = 1'b0;
    case (state)
      ST_STABLE: begin
        if (sync2 != level) begin
          if (DEBOUNCE_CYCLES == 1) begin
            // Single-cycle debounce accepts immediately, WAIT never entered
            flip_c = 1'b1;
            cnt_nx = '0;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = CW'(1);
          end
        end else begin
          cnt_nx = '0;
        end
      end
      ST_WAIT: begin
        if (sync2 == level) begin
          // Glitch: drop partial progress silently
          state_nx = ST_STABLE;
          cnt_nx   = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          flip_c   = 1'b1;
          state_nx = ST_STABLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = ST_STABLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_in,
  input  logic       key_in,
  output logic       w,
  output logic       w_rise,
  output logic       w_fall,
  output logic       step,
  output logic [7:0] step_count
);

  // Raw key level when the button is not pressed
  localparam logic KEY_RELEASED = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic sw_level;
  logic sw_flip_c;
  logic key_level;
  logic key_flip_c;
  logic step_nx;

  input_conditioner_db #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (1'b0)
  ) u_sw_db (
    .clk    (clk),
    .reset  (reset),
    .pin    (sw_in),
    .level  (sw_level),
    .flip_c (sw_flip_c)
  );

  input_conditioner_db #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (KEY_RELEASED)
  ) u_key_db (
    .clk    (clk),
    .reset  (reset),
    .pin    (key_in),
    .level  (key_level),
    .flip_c (key_flip_c)
  );

  // The accepted switch level is itself a register
  assign w = sw_level;

  // Only a released->pressed flip produces a step
  assign step_nx = key_flip_c & (key_level == KEY_RELEASED);

  // Registered edge pulses and press counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_rise     <= 1'b0;
      w_fall     <= 1'b0;
      step       <= 1'b0;
      step_count <= 8'd0;
    end else begin
      w_rise     <= sw_flip_c & ~sw_level;
      w_fall     <= sw_flip_c & sw_level;
      step       <= step_nx;
      step_count <= step_count + 8'(step_nx);
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, active-low key.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw_in;
  logic       key_in;
  logic       w;
  logic       w_rise;
  logic       w_fall;
  logic       step;
  logic [7:0] step_count;

  int n_vec  = 0;
  int n_err  = 0;
  int n_rise = 0;
  int n_fall = 0;
  int n_step = 0;
  int n_both = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_in      (sw_in),
    .key_in     (key_in),
    .w          (w),
    .w_rise     (w_rise),
    .w_fall     (w_fall),
    .step       (step),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then settle and tally output pulses
  task automatic tick();
    @(posedge clk);
    #1;
    if (w_rise) n_rise++;
    if (w_fall) n_fall++;
    if (step) n_step++;
    if (w_rise && w_fall) n_both++;
  endtask

  initial begin
    int r0, f0, s0;
    reset  = 1'b0;
    sw_in  = 1'b0;
    key_in = 1'b1;

    // Reset hold
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_w", int'(w), 0);
      chk("rst_pulses", int'({w_rise, w_fall, step}), 0);
      chk("rst_count", int'(step_count), 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("idle_w", int'(w), 0);
    chk("idle_pulses", n_rise + n_fall + n_step, 0);
    chk("idle_count", int'(step_count), 0);

    // Clean rising edge: accepted at the 6th sampling edge
    sw_in = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("clean_rise_w_%0d", i), int'(w), (i >= 6) ? 1 : 0);
      chk($sformatf("clean_rise_p_%0d", i), int'(w_rise), (i == 6) ? 1 : 0);
    end
    chk("clean_no_fall", n_fall, 0);
    for (int i = 0; i < 4; i++) tick();
    sw_in = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("clean_fall_w_%0d", i), int'(w), (i >= 6) ? 0 : 1);
      chk($sformatf("clean_fall_p_%0d", i), int'(w_fall), (i == 6) ? 1 : 0);
    end
    chk("clean_rise_total", n_rise, 1);
    chk("clean_fall_total", n_fall, 1);

    // Short glitch: high for 3 edges only
    r0 = n_rise; f0 = n_fall;
    sw_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    sw_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch_w", int'(w), 0);
    end
    chk("glitch_pulses", (n_rise - r0) + (n_fall - f0), 0);

    // Bounce: toggle every edge, ending low, then hold high
    for (int i = 0; i < 10; i++) begin
      sw_in = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      chk("bounce_w", int'(w), 0);
    end
    sw_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("bounce_w_%0d", i), int'(w), (i >= 6) ? 1 : 0);
    end
    chk("bounce_one_rise", n_rise - r0, 1);
    chk("bounce_no_fall", n_fall - f0, 0);

    // Key press held 30 edges: one step at the 6th edge, none on release
    s0 = n_step;
    key_in = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk($sformatf("press_step_%0d", i), int'(step), (i == 6) ? 1 : 0);
      chk($sformatf("press_cnt_%0d", i), int'(step_count), (i >= 6) ? 1 : 0);
    end
    key_in = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("press_one_step", n_step - s0, 1);
    chk("release_count", int'(step_count), 1);

    // Key glitch: 3 edges low
    key_in = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    key_in = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("key_glitch_steps", n_step - s0, 1);
    chk("key_glitch_count", int'(step_count), 1);

    // Counter wrap from a fresh reset
    reset = 1'b0;
    sw_in = 1'b0;
    tick();
    chk("wrap_rst_count", int'(step_count), 0);
    chk("wrap_rst_w", int'(w), 0);
    reset = 1'b1;
    s0 = n_step;
    for (int p = 1; p <= 256; p++) begin
      key_in = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk($sformatf("wrap_cnt_%0d", p), int'(step_count), p % 256);
      key_in = 1'b1;
      for (int i = 0; i < 8; i++) tick();
    end
    chk("wrap_steps", n_step - s0, 256);

    // Reset mid-debounce discards progress
    r0 = n_rise;
    sw_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    tick();
    chk("midrst_w", int'(w), 0);
    chk("midrst_rise", int'(w_rise), 0);
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("midrst_w_%0d", i), int'(w), (i >= 6) ? 1 : 0);
      chk($sformatf("midrst_p_%0d", i), int'(w_rise), (i == 6) ? 1 : 0);
    end
    chk("midrst_one_rise", n_rise - r0, 1);

    chk("rise_fall_exclusive", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
